imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed program into a small instruction
// memory over a valid/ready word stream and enables the processor run once
// the program is resident. Optional macro IMEM_LOADER_CSUM_EN adds a trailing
// XOR checksum word that must match before the program is released.
// Supported parameter range: 2 <= DEPTH <= 16, WIDTH >= 5.
module imem_loader #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             Resetn,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic [3:0]       rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             run_en,
    output logic             load_err,
    output logic [4:0]       count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [5:0] DEPTH_W = 6'(DEPTH);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [4:0]       count_r;
    logic [4:0]       count_nxt_s;
    logic [4:0]       len_r;
    logic [4:0]       len_nxt_s;
    logic             in_ready_r;
    logic             run_en_r;
    logic             load_err_r;
    logic             accept_s;
    logic             wr_en_s;
    logic [AW-1:0]    wr_idx_s;
    logic [AW-1:0]    rd_idx_s;
    logic             rd_hit_s;
    logic [4:0]       hdr_len_s;
    logic             hdr_bad_s;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rd_data_r;

`ifdef IMEM_LOADER_CSUM_EN
    logic [WIDTH-1:0] csum_r;
    logic [WIDTH-1:0] csum_nxt_s;

    // Running XOR checksum: fold one accepted instruction word into the sum.
    function automatic logic [WIDTH-1:0] csum_fold(
        input logic [WIDTH-1:0] acc,
        input logic [WIDTH-1:0] word
    );
        return acc ^ word;
    endfunction
`endif

    // A word moves only on a valid & ready edge; ready is a registered flag.
    assign accept_s  = in_valid & in_ready_r;
    assign hdr_len_s = in_data[4:0];
    // Length must lie in 1..DEPTH, anything else is a malformed header.
    assign hdr_bad_s = (hdr_len_s == 5'd0) || ({1'b0, hdr_len_s} > DEPTH_W);
    assign wr_idx_s  = count_r[AW-1:0];

    // Full 16-entry memory maps the 4-bit fetch address directly; a smaller
    // memory returns zero for fetches beyond its last word.
    generate
        if (DEPTH == 16) begin : g_rd_full
            assign rd_idx_s = rd_addr;
            assign rd_hit_s = 1'b1;
        end else begin : g_rd_part
            assign rd_idx_s = rd_addr[AW-1:0];
            assign rd_hit_s = ({1'b0, rd_addr} < 5'(DEPTH));
        end
    endgenerate

    // State register; reset aborts any load in progress.
    always_ff @(posedge clk) begin
        if (!Resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and datapath-update decode for the load sequence.
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        len_nxt_s   = len_r;
        wr_en_s     = 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
        csum_nxt_s  = csum_r;
`endif
        case (state_r)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_nxt_s = HDR;
                    count_nxt_s = 5'd0;
`ifdef IMEM_LOADER_CSUM_EN
                    csum_nxt_s  = {WIDTH{1'b0}};
`endif
                end else begin
                    state_nxt_s = state_r;
                end
            end
            HDR: begin
                if (accept_s) begin
                    len_nxt_s = hdr_len_s;
                    if (hdr_bad_s) begin
                        state_nxt_s = ERR;
                    end else begin
                        state_nxt_s = DATA;
                    end
                end else begin
                    state_nxt_s = HDR;
                end
            end
            DATA: begin
                if (accept_s) begin
                    wr_en_s     = 1'b1;
                    count_nxt_s = count_r + 5'd1;
`ifdef IMEM_LOADER_CSUM_EN
                    csum_nxt_s  = csum_fold(csum_r, in_data);
`endif
                    if ((count_r + 5'd1) == len_r) begin
`ifdef IMEM_LOADER_CSUM_EN
                        state_nxt_s = CSUM;
`else
                        state_nxt_s = DONE;
`endif
                    end else begin
                        state_nxt_s = DATA;
                    end
                end else begin
                    state_nxt_s = DATA;
                end
            end
`ifdef IMEM_LOADER_CSUM_EN
            CSUM: begin
                if (accept_s) begin
                    if (in_data == csum_r) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = ERR;
                    end
                end else begin
                    state_nxt_s = CSUM;
                end
            end
`endif
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Registered status outputs derived from the state being entered.
    always_ff @(posedge clk) begin
        if (!Resetn) begin
            count_r    <= 5'd0;
            len_r      <= 5'd0;
            in_ready_r <= 1'b0;
            run_en_r   <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            count_r    <= count_nxt_s;
            len_r      <= len_nxt_s;
            in_ready_r <= (state_nxt_s == HDR) || (state_nxt_s == DATA) ||
                          (state_nxt_s == CSUM);
            run_en_r   <= (state_nxt_s == DONE);
            load_err_r <= (state_nxt_s == ERR);
        end
    end

`ifdef IMEM_LOADER_CSUM_EN
    // Checksum accumulator, cleared on start and on reset.
    always_ff @(posedge clk) begin
        if (!Resetn) begin
            csum_r <= {WIDTH{1'b0}};
        end else begin
            csum_r <= csum_nxt_s;
        end
    end
`endif

    // Instruction memory with registered read; a same-address write lands
    // after the read samples, so the fetch returns the previous contents.
    always_ff @(posedge clk) begin
        if (!Resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            rd_data_r <= {WIDTH{1'b0}};
        end else begin
            if (wr_en_s) begin
                mem_r[wr_idx_s] <= in_data;
            end
            if (rd_hit_s) begin
                rd_data_r <= mem_r[rd_idx_s];
            end else begin
                rd_data_r <= {WIDTH{1'b0}};
            end
        end
    end

    assign in_ready = in_ready_r;
    assign run_en   = run_en_r;
    assign load_err = load_err_r;
    assign count    = count_r;
    assign rd_data  = rd_data_r;

endmodule
